// File: rtl/id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// id_stage_pipelined
//
// Pipelined MIPS instruction-decode stage. It decodes the instruction held in
// the IF/ID register, reads two operands from an internal 32-entry register
// file and captures everything into a registered ID/EX slot. Both sides use
// valid/ready handshakes. A load in the ID/EX slot whose destination feeds the
// incoming instruction causes exactly one bubble. A saturating counter records
// how many bubbles were inserted.
//
// Parameters
//   NBITS        datapath / register width (>= 32); immediates extend to NBITS
//   STALL_CNT_W  width of the hazard-bubble counter
//
// Ports
//   i_clk, i_rst            clock (rising edge), asynchronous active-low reset
//   i_valid, o_ready        upstream handshake (IF/ID -> ID)
//   i_pc, i_instruction     PC+4 and instruction of the incoming word
//   i_flush                 squash the ID/EX slot and drop the incoming word
//   i_wr_en, i_rd_sel,
//   i_wr_data               write-back port into the register file
//   i_ready, o_valid        downstream handshake (ID/EX -> EX)
//   o_pc .. o_mem_read      registered decode results of the ID/EX slot
//   o_stall_cnt             saturating count of inserted hazard bubbles
// -----------------------------------------------------------------------------
module id_stage_pipelined #(
    parameter int NBITS       = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,

    input  logic                   i_valid,
    input  logic [NBITS-1:0]       i_pc,
    input  logic [31:0]            i_instruction,
    output logic                   o_ready,
    input  logic                   i_flush,

    input  logic                   i_wr_en,
    input  logic [4:0]             i_rd_sel,
    input  logic [NBITS-1:0]       i_wr_data,

    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [NBITS-1:0]       o_pc,
    output logic [NBITS-1:0]       o_rs_data,
    output logic [NBITS-1:0]       o_rt_data,
    output logic [NBITS-1:0]       o_imm_ext,
    output logic [5:0]             o_opcode,
    output logic [5:0]             o_funct,
    output logic [4:0]             o_rs,
    output logic [4:0]             o_rt,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_shamt,
    output logic                   o_mem_read,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    // -------------------------------------------------------------------------
    // Opcodes with special decode behaviour
    // -------------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t state, state_next;

    // -------------------------------------------------------------------------
    // Instruction fields
    // -------------------------------------------------------------------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = i_instruction[31:26];
    assign rs     = i_instruction[25:21];
    assign rt     = i_instruction[20:16];
    assign rd     = i_instruction[15:11];
    assign shamt  = i_instruction[10:6];
    assign funct  = i_instruction[5:0];
    assign imm    = i_instruction[15:0];

    // -------------------------------------------------------------------------
    // Register file: r0 is hard-wired to zero and never written.
    // -------------------------------------------------------------------------
    logic [NBITS-1:0] rf [32];

    // NOTE: the register file is explicitly cleared by reset, so it must live
    // in an async-reset flop array rather than an inferred RAM macro.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (i_wr_en && (i_rd_sel != 5'd0)) begin
            // NOTE: state updates use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            rf[i_rd_sel] <= i_wr_data;
        end
    end

    // Reads see a same-cycle write-back (bypass); r0 always reads zero.
    logic [NBITS-1:0] rs_data;
    logic [NBITS-1:0] rt_data;

    assign rs_data = (rs == 5'd0)                     ? '0        :
                     (i_wr_en && (i_rd_sel == rs))    ? i_wr_data :
                                                        rf[rs];
    assign rt_data = (rt == 5'd0)                     ? '0        :
                     (i_wr_en && (i_rd_sel == rt))    ? i_wr_data :
                                                        rf[rt];

    // -------------------------------------------------------------------------
    // Immediate extension
    // -------------------------------------------------------------------------
    logic [NBITS-1:0] imm_ext;

    // NOTE: every variable written in a combinational block gets a default on
    // entry so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        imm_ext = '0;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: begin
                imm_ext[15:0] = imm;
            end
            OP_LUI: begin
                // {imm,16'b0} is treated as a signed 32-bit value and widened.
                imm_ext        = {NBITS{imm[15]}};
                imm_ext[31:0]  = {imm, 16'h0000};
            end
            default: begin
                imm_ext        = {NBITS{imm[15]}};
                imm_ext[15:0]  = imm;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand usage and load detection
    // -------------------------------------------------------------------------
    logic is_load;
    logic rs_used;
    logic rt_used;

    assign is_load = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU};
    assign rs_used = !(opcode inside {OP_J, OP_JAL});
    assign rt_used = opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW};

    // -------------------------------------------------------------------------
    // Load-use hazard: the load sitting in ID/EX writes a register that the
    // incoming instruction reads. Its data only exists after MEM, so the
    // dependent instruction has to wait one cycle.
    // -------------------------------------------------------------------------
    logic hazard;
    logic adv;

    assign hazard = i_valid && o_valid && o_mem_read && (o_rt != 5'd0) &&
                    (((o_rt == rs) && rs_used) || ((o_rt == rt) && rt_used));

    // The ID/EX slot may be overwritten when it is empty or EX is taking it.
    assign adv = !o_valid || i_ready;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    logic load_slot;    // capture the decoded instruction
    logic clear_slot;   // empty the ID/EX slot
    logic stall_inc;    // a bubble is being inserted

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        load_slot  = 1'b0;
        clear_slot = 1'b0;
        stall_inc  = 1'b0;

        if (i_flush) begin
            // Flush wins over hazard and backpressure; the incoming word is
            // consumed and thrown away.
            o_ready    = 1'b1;
            clear_slot = 1'b1;
            state_next = RUN;
        end else if (adv && hazard && (state == RUN)) begin
            // Hold the dependent instruction upstream and send a bubble.
            clear_slot = 1'b1;
            stall_inc  = 1'b1;
            state_next = BUBBLE;
        end else if (adv) begin
            // In BUBBLE the hazard is ignored: the load has moved on, so the
            // dependent instruction is accepted now.
            o_ready    = 1'b1;
            state_next = RUN;
            if (i_valid) begin
                load_slot  = 1'b1;
            end else begin
                clear_slot = 1'b1;
            end
        end
        // Otherwise EX is stalling a full slot: everything holds.
    end

    // -------------------------------------------------------------------------
    // ID/EX register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_rs_data  <= '0;
            o_rt_data  <= '0;
            o_imm_ext  <= '0;
            o_opcode   <= '0;
            o_funct    <= '0;
            o_rs       <= '0;
            o_rt       <= '0;
            o_rd       <= '0;
            o_shamt    <= '0;
            o_mem_read <= 1'b0;
        end else if (load_slot) begin
            o_valid    <= 1'b1;
            o_pc       <= i_pc;
            o_rs_data  <= rs_data;
            o_rt_data  <= rt_data;
            o_imm_ext  <= imm_ext;
            o_opcode   <= opcode;
            o_funct    <= funct;
            o_rs       <= rs;
            o_rt       <= rt;
            o_rd       <= rd;
            o_shamt    <= shamt;
            o_mem_read <= is_load;
        end else if (clear_slot) begin
            o_valid    <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating bubble counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_stall_cnt <= '0;
        end else if (stall_inc && (o_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_id_stage_pipelined
//
// Self-checking bench for id_stage_pipelined. A directed prologue covers
// bypass, load-use bubbles, immediates, backpressure, flush and counter
// saturation. It is followed by a randomized run. Each cycle is compared with
// a behavioural model that tracks the ID/EX slot, a bubble flag, the bubble
// count and the register contents. A second instance with a 2-bit counter
// receives the same stimulus and is used to check saturation.
// -----------------------------------------------------------------------------
module tb_id_stage_pipelined;

    localparam int NBITS = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic [NBITS-1:0]  pc_in = '0;
    logic [31:0]       instr_in = '0;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [4:0]        rd_sel = '0;
    logic [NBITS-1:0]  wr_data = '0;
    logic              ready_in = 1'b0;

    logic              ready_out, valid_out, mem_read;
    logic [NBITS-1:0]  pc_out, rs_data, rt_data, imm_ext;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [CNT_W-1:0]  stall_cnt;

    logic              b_ready, b_valid, b_mem_read;
    logic [NBITS-1:0]  b_pc, b_rs_data, b_rt_data, b_imm_ext;
    logic [5:0]        b_opcode, b_funct;
    logic [4:0]        b_rs, b_rt, b_rd, b_shamt;
    logic [SAT_W-1:0]  b_stall_cnt;

    id_stage_pipelined #(.NBITS(NBITS), .STALL_CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .i_pc(pc_in),
        .i_instruction(instr_in), .o_ready(ready_out), .i_flush(flush),
        .i_wr_en(wr_en), .i_rd_sel(rd_sel), .i_wr_data(wr_data),
        .i_ready(ready_in), .o_valid(valid_out), .o_pc(pc_out),
        .o_rs_data(rs_data), .o_rt_data(rt_data), .o_imm_ext(imm_ext),
        .o_opcode(opcode), .o_funct(funct), .o_rs(rs), .o_rt(rt), .o_rd(rd),
        .o_shamt(shamt), .o_mem_read(mem_read), .o_stall_cnt(stall_cnt)
    );

    id_stage_pipelined #(.NBITS(NBITS), .STALL_CNT_W(SAT_W)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .i_pc(pc_in),
        .i_instruction(instr_in), .o_ready(b_ready), .i_flush(flush),
        .i_wr_en(wr_en), .i_rd_sel(rd_sel), .i_wr_data(wr_data),
        .i_ready(ready_in), .o_valid(b_valid), .o_pc(b_pc),
        .o_rs_data(b_rs_data), .o_rt_data(b_rt_data), .o_imm_ext(b_imm_ext),
        .o_opcode(b_opcode), .o_funct(b_funct), .o_rs(b_rs), .o_rt(b_rt),
        .o_rd(b_rd), .o_shamt(b_shamt), .o_mem_read(b_mem_read),
        .o_stall_cnt(b_stall_cnt)
    );

    // ------------------------------------------------------------------ check
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct {
        logic             valid;
        logic [NBITS-1:0] pc, rs_data, rt_data, imm;
        logic [5:0]       op, fn;
        logic [4:0]       rs, rt, rd, sh;
        logic             mr;
    } slot_t;

    slot_t            m_slot;
    logic             m_after_bubble;
    longint           m_stalls;
    logic [NBITS-1:0] m_regs [32];
    logic             last_ready;

    function automatic logic [NBITS-1:0] model_imm(input logic [5:0] op, input logic [15:0] imm);
        longint v;
        v = longint'(imm);
        if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            // zero-extended: v already holds the unsigned value
        end else if (op == 6'h0F) begin
            v = v * 65536;
            if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
        end else begin
            if (v >= 32768) v = v - 65536;
        end
        return NBITS'(v);
    endfunction

    function automatic logic [NBITS-1:0] model_read(input logic [4:0] sel);
        if (sel == 5'd0) return '0;
        if (wr_en && rd_sel == sel) return wr_data;
        return m_regs[sel];
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint max_v;
        max_v = (longint'(1) << w) - 1;
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic check_outputs();
        check("o_valid", valid_out, m_slot.valid);
        if (m_slot.valid) begin
            check("o_pc",       pc_out,   m_slot.pc);
            check("o_rs_data",  rs_data,  m_slot.rs_data);
            check("o_rt_data",  rt_data,  m_slot.rt_data);
            check("o_imm_ext",  imm_ext,  m_slot.imm);
            check("o_opcode",   opcode,   m_slot.op);
            check("o_funct",    funct,    m_slot.fn);
            check("o_rs",       rs,       m_slot.rs);
            check("o_rt",       rt,       m_slot.rt);
            check("o_rd",       rd,       m_slot.rd);
            check("o_shamt",    shamt,    m_slot.sh);
            check("o_mem_read", mem_read, m_slot.mr);
        end
        check("stall_cnt",     stall_cnt,   sat(m_stalls, CNT_W));
        check("stall_cnt_sat", b_stall_cnt, sat(m_stalls, SAT_W));
    endtask

    // One clock cycle: drive, check o_ready, advance model across the edge,
    // check registered outputs. Entered and left at posedge + 1.
    task automatic cycle(input logic v, input logic [NBITS-1:0] pc, input logic [31:0] instr,
                         input logic fl, input logic rdy, input logic we,
                         input logic [4:0] wsel, input logic [NBITS-1:0] wdat);
        slot_t      nxt;
        logic       nxt_bubble, adv, haz, use_rs, use_rt, exp_ready;
        logic [5:0] op;
        logic [4:0] f_rs, f_rt;

        valid_in = v; pc_in = pc; instr_in = instr; flush = fl; ready_in = rdy;
        wr_en = we; rd_sel = wsel; wr_data = wdat;
        #1;
        op   = instr[31:26];
        f_rs = instr[25:21];
        f_rt = instr[20:16];
        use_rs = !(op inside {6'h02, 6'h03});
        use_rt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        adv = !m_slot.valid || rdy;
        haz = !m_after_bubble && v && m_slot.valid && m_slot.mr && (m_slot.rt != 0) &&
              (((m_slot.rt == f_rs) && use_rs) || ((m_slot.rt == f_rt) && use_rt));
        exp_ready = fl || (adv && !haz);
        check("o_ready", ready_out, exp_ready);
        last_ready = exp_ready;

        nxt = m_slot;
        nxt_bubble = m_after_bubble;
        if (fl) begin
            nxt.valid = 1'b0;
            nxt_bubble = 1'b0;
        end else if (adv && haz) begin
            nxt.valid = 1'b0;
            nxt_bubble = 1'b1;
            m_stalls++;
        end else if (adv) begin
            nxt_bubble = 1'b0;
            if (v) begin
                nxt.valid   = 1'b1;
                nxt.pc      = pc;
                nxt.rs_data = model_read(f_rs);
                nxt.rt_data = model_read(f_rt);
                nxt.imm     = model_imm(op, instr[15:0]);
                nxt.op      = op;
                nxt.fn      = instr[5:0];
                nxt.rs      = f_rs;
                nxt.rt      = f_rt;
                nxt.rd      = instr[15:11];
                nxt.sh      = instr[10:6];
                nxt.mr      = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27};
            end else begin
                nxt.valid = 1'b0;
            end
        end

        @(posedge clk);
        if (we && wsel != 0) m_regs[wsel] = wdat;
        m_slot = nxt;
        m_after_bubble = nxt_bubble;
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        check("rst_valid",    valid_out,   1'b0);
        check("rst_pc",       pc_out,      '0);
        check("rst_rs_data",  rs_data,     '0);
        check("rst_imm",      imm_ext,     '0);
        check("rst_opcode",   opcode,      '0);
        check("rst_mem_read", mem_read,    1'b0);
        check("rst_stall",    stall_cnt,   '0);
        check("rst_stall_b",  b_stall_cnt, '0);
        m_slot = '{default: '0};
        m_after_bubble = 1'b0;
        m_stalls = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------- encoders
    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [18];
        logic [31:0] r;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23,
                6'h24, 6'h25, 6'h27, 6'h2B, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 17)];
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    // --------------------------------------------------------------- stimulus
    localparam logic [31:0] LW_R8  = {6'h23, 5'd1, 5'd8, 16'h0000};
    localparam logic [31:0] LW_R0  = {6'h23, 5'd1, 5'd0, 16'h0000};

    initial begin
        logic [31:0]      add_dep, r_instr;
        logic [NBITS-1:0] r_pc;
        logic             r_v, hold;

        @(posedge clk);
        #1;
        apply_reset();

        // Same-cycle write-back bypass into a decoded operand.
        cycle(1, 32'h4, rtype(5, 0, 3, 6'h20), 0, 1, 1, 5, 32'h1234);
        check("bypass_rs", rs_data, 32'h1234);
        check("bypass_valid", valid_out, 1'b1);
        cycle(0, 32'h0, 32'h0, 0, 1, 1, 1, 32'h100);
        cycle(0, 32'h0, 32'h0, 0, 1, 1, 2, 32'h22);

        // Load-use: exactly one bubble.
        add_dep = rtype(8, 2, 9, 6'h20);
        cycle(1, 32'h10, LW_R8, 0, 1, 0, 0, 0);
        cycle(1, 32'h14, add_dep, 0, 1, 0, 0, 0);
        check("lu_bubble_valid", valid_out, 1'b0);
        check("lu_stall_cnt", stall_cnt, 1);
        cycle(1, 32'h14, add_dep, 0, 1, 0, 0, 0);
        check("lu_issue_rd", rd, 5'd9);
        check("lu_issue_rt_data", rt_data, 32'h22);

        // Independent instruction after a load, and a load to r0.
        cycle(1, 32'h18, LW_R8, 0, 1, 0, 0, 0);
        cycle(1, 32'h1C, itype(6'h08, 0, 9, 16'd5), 0, 1, 0, 0, 0);
        check("nodep_opcode", opcode, 6'h08);
        cycle(1, 32'h20, LW_R0, 0, 1, 0, 0, 0);
        cycle(1, 32'h24, rtype(0, 0, 9, 6'h20), 0, 1, 0, 0, 0);
        check("r0_no_stall", stall_cnt, 1);

        // Immediate extension.
        cycle(1, 32'h28, itype(6'h0D, 0, 4, 16'h8000), 0, 1, 0, 0, 0);
        check("imm_ori", imm_ext, 32'h0000_8000);
        cycle(1, 32'h2C, itype(6'h08, 0, 4, 16'h8000), 0, 1, 0, 0, 0);
        check("imm_addi", imm_ext, 32'hFFFF_8000);
        cycle(1, 32'h30, itype(6'h0F, 0, 4, 16'h8000), 0, 1, 0, 0, 0);
        check("imm_lui", imm_ext, 32'h8000_0000);

        // Backpressure for three cycles, then flush during the hold.
        cycle(1, 32'h34, rtype(1, 2, 10, 6'h20), 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'h38, rtype(1, 2, 11, 6'h22), 0, 0, 0, 0, 0);
            check("hold_rd", rd, 5'd10);
        end
        cycle(1, 32'h38, rtype(1, 2, 11, 6'h22), 1, 0, 0, 0, 0);
        check("flush_valid", valid_out, 1'b0);

        // Five more load-use pairs: the 2-bit counter saturates.
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'h40, LW_R8, 0, 1, 0, 0, 0);
            cycle(1, 32'h44, add_dep, 0, 1, 0, 0, 0);
            cycle(1, 32'h44, add_dep, 0, 1, 0, 0, 0);
        end
        check("stall_cnt_6", stall_cnt, 6);
        check("stall_sat_3", b_stall_cnt, 2'd3);

        // Randomized run with a mid-run reset.
        hold = 1'b0;
        r_v = 1'b0; r_pc = '0; r_instr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                apply_reset();
                hold = 1'b0;
            end
            if (!hold) begin
                r_v     = ($urandom_range(0, 3) != 0);
                r_pc    = $urandom;
                r_instr = rand_instr();
            end
            cycle(r_v, r_pc, r_instr,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            hold = r_v && !last_ready;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Pipelined instruction-decode stage with a registered ID/EX output, valid/ready handshakes on both sides and an internal register file. It generalises the combinational decode stage: parametrised data width, in-stage load-use hazard detection with automatic bubble insertion, flush, backpressure and a saturating stall counter. It sits between the IF/ID register and the execute stage; the write-back stage drives its register-file write port.

## Interface
- NBITS, 32, datapath/register width (≥32); immediates extend to NBITS
- STALL_CNT_W, 16, width of the hazard-stall counter
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_pc  in  NBITS  PC+4 of incoming instruction
- i_instruction  in  32  incoming MIPS instruction
- o_ready  out  1  stage consumes the incoming instruction this cycle
- i_flush  in  1  squash the ID/EX contents and the incoming instruction
- i_wr_en  in  1  WB register write enable
- i_rd_sel  in  5  WB destination register
- i_wr_data  in  NBITS  WB write data
- i_ready  in  1  EX accepts the ID/EX contents
- o_valid  out  1  ID/EX contents valid
- o_pc  out  NBITS  captured PC
- o_rs_data, o_rt_data  out  NBITS  register operands
- o_imm_ext  out  NBITS  extended immediate
- o_opcode, o_funct  out  6  instruction fields
- o_rs, o_rt, o_rd, o_shamt  out  5  instruction fields
- o_mem_read  out  1  instruction is a load
- o_stall_cnt  out  STALL_CNT_W  saturating count of hazard bubbles

## Operation
- Register file: 32×NBITS; r0 reads 0 and ignores writes. Write on rising edge when i_wr_en. Same-cycle write bypass: a read of i_rd_sel with i_wr_en high returns i_wr_data, except for r0.
- Immediate: zero-extend for opcodes 0x0C/0x0D/0x0E (ANDI/ORI/XORI); LUI (0x0F) gives {imm,16'b0} sign-extended to NBITS; all others sign-extend.
- Load opcodes: 0x20, 0x21, 0x23, 0x24, 0x25, 0x27; o_mem_read is set for these.
- rs used by every opcode except 0x02/0x03 (J/JAL). rt used by opcode 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
- hazard = i_valid & o_valid & o_mem_read & (o_rt≠0) & ((o_rt==rs & rs used) | (o_rt==rt & rt used)).
- adv = ~o_valid | i_ready (the ID/EX slot can be written).
- FSM states: RUN, BUBBLE.
  - RUN: if i_flush, o_valid←0 and o_ready=1 (incoming instruction dropped). Else if adv & hazard, o_valid←0, o_ready=0, counter+1 (saturating) and go to BUBBLE. Else if adv, o_ready=1; when i_valid the slot loads the decoded fields and o_valid←1, otherwise o_valid←0. Else (~adv) everything holds and o_ready=0.
  - BUBBLE: hazard is ignored for one accept. Flush behaves as in RUN and returns to RUN. If adv, accept as in RUN and return to RUN; otherwise hold.
- Upstream keeps i_pc and i_instruction stable while i_valid & ~o_ready.
- Captured operands are not refreshed by later WB writes; forwarding is EX's job.

## Timing
- Reset (i_rst=0, async): all outputs 0, register file cleared, state RUN, o_stall_cnt=0.
- o_ready is combinational from i_valid, i_flush, i_ready and the stage state. All other outputs are registered.
- Latency: an instruction accepted at edge N is presented with o_valid=1 after edge N.
- A load followed by a dependent instruction costs exactly one bubble cycle.
- i_flush has priority over hazard and backpressure.
- o_stall_cnt saturates at 2^STALL_CNT_W−1 and never wraps.
- Reset mid-operation discards the ID/EX contents immediately.

## Test plan
- Reset, then WB writes r5=0x1234 while ADD r3,r5,r0 is decoded in the same cycle -> o_rs_data=0x1234 (bypass) and o_valid rises one cycle after accept.
- LW r8,0(r1) then ADD r9,r8,r2 with i_ready=1 -> one cycle with o_valid=0 and o_ready=0, ADD issued on the next edge, o_stall_cnt=1.
- LW r8 then ADDI r9,r0,5 (no dependency) -> back-to-back issue, no bubble. LW r0 then use of r0 -> no bubble.
- Immediates: ORI imm 0x8000 -> 0x00008000; ADDI imm 0x8000 -> 0xFFFF8000; LUI imm 0x8000 -> 0x80000000.
- i_ready=0 for 3 cycles with o_valid=1 -> outputs stable and o_ready=0; i_flush asserted during this hold -> o_valid=0 next edge.
- STALL_CNT_W=2 with 5 load-use pairs -> o_stall_cnt stops at 3.
